// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam logic [31:0] END_OF_PROG  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          QDEPTH       = 2;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instr, pc}; entry 0 is always the head, so the head is a plain register.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_data,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_ok, push_ok;

    assign pop_ok  = pop && (cnt_q != 2'd0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && ((cnt_q < 2'(QDEPTH)) || pop_ok);

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else if (pop_ok && push_ok) begin
            if (cnt_q == 2'd1) begin
                ent0_d = push_data;
            end else begin
                ent0_d = ent1_q;
                ent1_d = push_data;
            end
        end else if (pop_ok) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end else if (push_ok) begin
            if (cnt_q == 2'd0) begin
                ent0_d = push_data;
            end else begin
                ent1_d = push_data;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = ent0_q;

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, drives the combinational ROM, queues words for decode
// and applies execute redirects. Stops on the end-of-program word or a misaligned target.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [31:0]       instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [1:0]        dbg_state
);

    localparam int QW = DATA_W + 32;

    // Handshake: decode takes the head when instr_valid && instr_ready at a rising edge;
    // the head holds steady otherwise. A redirect wins over any fetch in its cycle.
    logic [31:0]      pc_q, pc_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       q_count;
    logic [QW-1:0]    q_head;
    logic             pop, redirect_take, aligned, fetch_go, eop, push;

    assign instr_valid   = (q_count != 2'd0);
    assign pop           = instr_valid && instr_ready;
    assign redirect_take = redirect_valid && (state_q != ERR);
    assign aligned       = (redirect_pc[1:0] == 2'b00);
    assign fetch_go      = (state_q == RUN) && !redirect_valid &&
                           ((q_count < 2'(QDEPTH)) || pop);
    assign eop           = (rom_data == DATA_W'(END_OF_PROG));
    assign push          = fetch_go && !eop;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pop && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (redirect_take) begin
            if (aligned) begin
                pc_d    = redirect_pc;
                state_d = RUN;
            end else begin
                state_d = ERR;
            end
        end else if (fetch_go) begin
            if (eop) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    fetch_queue #(.W(QW)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_take),
        .push_data ({rom_data, pc_q}),
        .count     (q_count),
        .head      (q_head)
    );

    // Stale entries stay in the queue after a flush, so the head is masked when empty.
    assign instr     = instr_valid ? q_head[QW-1:32] : '0;
    assign instr_pc  = instr_valid ? q_head[31:0]    : '0;
    assign rom_addr  = pc_q[ADDR_W+1:2];
    assign halted    = (state_q == HALT);
    assign fetch_err = (state_q == ERR);
    assign instr_cnt = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios then randomized traffic, all checked against
// a queue-based model of the fetch rules.
module tb_fetch_seq;

    localparam int TB_CNT_W = 6;
    localparam int unsigned CNT_MAX = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [4:0]          rom_addr;
    logic [31:0]         rom_data;
    logic                instr_valid;
    logic [31:0]         instr;
    logic [31:0]         instr_pc;
    logic                instr_ready;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                halted;
    logic                fetch_err;
    logic [TB_CNT_W-1:0] instr_cnt;
    logic [1:0]          dbg_state;

    logic [31:0] rom [32];
    assign rom_data = rom[rom_addr];

    fetch_seq #(.ADDR_W(5), .DATA_W(32), .RESET_PC(32'h0), .CNT_W(TB_CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_err      (fetch_err),
        .instr_cnt      (instr_cnt),
        .dbg_state      (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of {instr, pc}, fetch pointer, mode (0 run, 1 halted, 2 error), pop count.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    int          m_st;
    int unsigned m_cnt;
    int          tail_seen;
    int          w30_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("rom_addr", 64'(rom_addr), 64'(m_pc[6:2]));
        check("instr_valid", 64'(instr_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("instr", 64'(instr), 64'(exp_q[0][63:32]));
            check("instr_pc", 64'(instr_pc), 64'(exp_q[0][31:0]));
        end
        check("halted", 64'(halted), 64'(m_st == 1));
        check("fetch_err", 64'(fetch_err), 64'(m_st == 2));
        check("instr_cnt", 64'(instr_cnt), 64'(m_cnt));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc  = 32'h0;
        m_st  = 0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input logic rst_n, input logic rdy, input logic rv,
                              input logic [31:0] rpc);
        logic [31:0] w;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (exp_q.size() > 0 && rdy) begin
                exp_q.delete(0);
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (rv && m_st != 2) begin
                exp_q.delete();
                if (rpc[1:0] == 2'b00) begin
                    m_pc = rpc;
                    m_st = 0;
                end else begin
                    m_st = 2;
                end
            end else if (m_st == 0 && !rv && exp_q.size() < 2) begin
                w = rom[m_pc[6:2]];
                if (w != 32'h0) begin
                    exp_q.push_back({w, m_pc});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_st = 1;
                end
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset          = rst_n;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        compare_model();
        if (rst_n && instr_valid && rdy) begin
            if (instr_pc == 32'h6c || instr_pc == 32'h70 || instr_pc == 32'h74) tail_seen++;
            if (instr_pc == 32'h78) w30_seen++;
        end
        model_edge(rst_n, rdy, rv, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
        check({tag, "_valid"}, 64'(instr_valid), 64'(1));
        check({tag, "_instr"}, 64'(instr), 64'(exp_instr));
        check({tag, "_pc"}, 64'(instr_pc), 64'(exp_pc));
    endtask

    initial begin
        rom = '{32'h00300413, 32'h00100493, 32'h01000913, 32'h00940533,
                32'h00a484b3, 32'hfff40413, 32'hfe041ce3, 32'h00950593,
                32'h00b02023, 32'h00002603, 32'h00c60633, 32'h00160613,
                32'h00c02223, 32'h01228863, 32'h00148493, 32'h00248493,
                32'hff5ff06f, 32'h00000013, 32'h00100513, 32'h00a50533,
                32'h00a02423, 32'h00802283, 32'h00528293, 32'h00502623,
                32'h00c02303, 32'h00630333, 32'h00602823, 32'h01002383,
                32'h00738393, 32'h00702a23, 32'h00000000, 32'h0000006f};
        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tail_seen      = 0;
        w30_seen       = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_valid", 64'(instr_valid), 64'(0));
        check("rst_instr", 64'(instr), 64'(0));
        check("rst_pc", 64'(instr_pc), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_err", 64'(fetch_err), 64'(0));
        check("rst_cnt", 64'(instr_cnt), 64'(0));
        check("rst_rom_addr", 64'(rom_addr), 64'(0));

        // Straight-line fetch
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_head("line1", 32'h00300413, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_head("line2", 32'h00100493, 32'h4);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_head("line3", 32'h01000913, 32'h8);
        check("line3_cnt", 64'(instr_cnt), 64'(2));

        // Backpressure after the first valid
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            check_head("bp_hold", 32'h00300413, 32'h0);
            check("bp_rom_addr", 64'(rom_addr), 64'(2));
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect from the jump at 0x40 back to 0x34
        for (int i = 0; i < 40 && m_pc != 32'h40; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("reach_pc40", 64'(rom_addr), 64'(16));
        step(1'b1, 1'b1, 1'b1, 32'h34);
        check("redir_flush", 64'(instr_valid), 64'(0));
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_head("redir_tgt", 32'h01228863, 32'h34);

        // End of program at word 30, then restart from 0
        tail_seen = 0;
        w30_seen  = 0;
        step(1'b1, 1'b1, 1'b1, 32'h6c);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("eop_halted", 64'(halted), 64'(1));
        check("eop_tail", 64'(tail_seen), 64'(3));
        check("eop_w30", 64'(w30_seen), 64'(0));
        step(1'b1, 1'b1, 1'b1, 32'h0);
        check("eop_unhalt", 64'(halted), 64'(0));
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_head("eop_restart", 32'h00300413, 32'h0);

        // Misaligned redirect is sticky until reset
        step(1'b1, 1'b1, 1'b1, 32'h22);
        check("mis_err", 64'(fetch_err), 64'(1));
        check("mis_valid", 64'(instr_valid), 64'(0));
        step(1'b1, 1'b1, 1'b1, 32'h10);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("mis_sticky", 64'(fetch_err), 64'(1));
        check("mis_novalid", 64'(instr_valid), 64'(0));
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("mis_rst_err", 64'(fetch_err), 64'(0));
        check("mis_rst_addr", 64'(rom_addr), 64'(0));
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_head("mis_restart", 32'h00300413, 32'h0);

        // Reset with a full queue and a redirect held during reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h40);
        check("mid_rst_valid", 64'(instr_valid), 64'(0));
        check("mid_rst_cnt", 64'(instr_cnt), 64'(0));
        check("mid_rst_addr", 64'(rom_addr), 64'(0));
        step(1'b0, 1'b1, 1'b1, 32'h40);
        check("mid_rst_addr2", 64'(rom_addr), 64'(0));
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_head("mid_rst_restart", 32'h00300413, 32'h0);

        // Random ROM image with scattered end-of-program words
        for (int i = 0; i < 32; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 9) == 0) w = 32'h0;
            else if (w == 32'h0) w = 32'h1;
            rom[i] = w;
        end

        // Aligned redirects only and no reset: drives instr_cnt into saturation
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = 32'($urandom_range(0, 63)) << 2;
            step(1'b1, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), rpc);
        end

        // Fully random traffic including resets, misaligned and high-address targets
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rpc;
            rpc = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) rpc = rpc | 32'hFFFF_FF00;
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 14) == 0), rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
